// File: rtl/ps2_kbd_tx_if.sv
// Write-side and line-side signals of the PS/2 keyboard transmitter.
// master drives bytes and control; slave is the transmitter itself.
interface ps2_kbd_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       inhibit;
  logic       ovf_clr;
  logic       ps2_clk;
  logic       ps2_data;
  logic       full;
  logic       empty;
  logic       busy;
  logic       overflow;

  modport master (
    output wr_en, wr_data, inhibit, ovf_clr,
    input  ps2_clk, ps2_data, full, empty, busy, overflow
  );

  modport slave (
    input  wr_en, wr_data, inhibit, ovf_clr,
    output ps2_clk, ps2_data, full, empty, busy, overflow
  );
endinterface

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: buffers scancode bytes in a small FIFO and
// serialises each one as an 11-bit frame (start, 8 data LSB first, odd parity, stop).
module ps2_kbd_tx #(
  parameter int unsigned HALF = 4,
  parameter int unsigned GAP  = 8,
  parameter int unsigned AW   = 3
) (
  input  logic        clk,
  input  logic        rst,
  ps2_kbd_tx_if.slave bus
);

  localparam int unsigned Depth  = 1 << AW;
  localparam int unsigned CntMax = (HALF > GAP) ? HALF : GAP;
  localparam int unsigned CW     = $clog2(CntMax);

  localparam logic [AW:0]   DepthW = (AW+1)'(Depth);
  localparam logic [CW-1:0] HalfM1 = CW'(HALF - 1);
  localparam logic [CW-1:0] GapM1  = CW'(GAP - 1);
  localparam logic [3:0]    LastIdx = 4'd10;

  typedef enum logic [1:0] {
    StIdle,
    StBitHigh,
    StBitLow,
    StGap
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [Depth];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          ovf_q;

  // Serialiser state
  state_e        state_q;
  logic [CW-1:0] phase_q;
  logic [3:0]    idx_q;
  logic [9:0]    shift_q;
  logic          ps2_clk_q;
  logic          ps2_data_q;
  logic          busy_q;

  logic       push;
  logic       drop;
  logic       pop;
  logic [7:0] head;

  // full_q is the registered view, so a write while full is dropped even if a pop frees a slot.
  assign push = bus.wr_en && !full_q;
  assign drop = bus.wr_en && full_q;
  assign pop  = (state_q == StIdle) && !empty_q && !bus.inhibit;
  assign head = mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == DepthW);
      empty_q <= (count_d == '0);
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // shift_q holds the bits still to be sent after the start bit: data, parity, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q    <= StBitHigh;
            shift_q    <= {1'b1, ~^head, head};
            ps2_data_q <= 1'b0;
            busy_q     <= 1'b1;
            idx_q      <= '0;
            phase_q    <= '0;
          end
        end
        StBitHigh: begin
          if (phase_q == HalfM1) begin
            state_q   <= StBitLow;
            ps2_clk_q <= 1'b0;
            phase_q   <= '0;
          end else begin
            phase_q <= phase_q + CW'(1);
          end
        end
        StBitLow: begin
          if (phase_q == HalfM1) begin
            phase_q   <= '0;
            ps2_clk_q <= 1'b1;
            if (idx_q == LastIdx) begin
              state_q    <= StGap;
              ps2_data_q <= 1'b1;
            end else begin
              // Data only moves on the rising edge, so it is stable for the whole low phase.
              state_q    <= StBitHigh;
              ps2_data_q <= shift_q[0];
              shift_q    <= {1'b1, shift_q[9:1]};
              idx_q      <= idx_q + 4'd1;
            end
          end else begin
            phase_q <= phase_q + CW'(1);
          end
        end
        StGap: begin
          if (phase_q == GapM1) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + CW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ps2_clk  = ps2_clk_q;
  assign bus.ps2_data = ps2_data_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: directed scenarios plus random traffic, checked every cycle
// against a timing-formula reference model and a falling-edge frame decoder.
module tb_ps2_kbd_tx;

  localparam int unsigned HALF  = 4;
  localparam int unsigned GAP   = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int FT = 22 * HALF;
  localparam int BT = 22 * HALF + GAP;
  localparam int PERIOD = BT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(
    .HALF (HALF),
    .GAP  (GAP),
    .AW   (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs as sampled by the DUT at the most recent rising edge.
  logic       s_rst = 1'b1;
  logic       s_wr  = 1'b0;
  logic       s_inh = 1'b0;
  logic       s_clr = 1'b0;
  logic [7:0] s_data = 8'h00;

  always @(posedge clk) begin
    s_rst  = rst;
    s_wr   = bus.wr_en;
    s_inh  = bus.inhibit;
    s_clr  = bus.ovf_clr;
    s_data = bus.wr_data;
  end

  // Reference model state
  logic [7:0]  fifo_m [$];
  logic [7:0]  sent_q [$];
  int          first_fall [$];
  bit          ovf_m = 1'b0;
  bit          in_frame = 1'b0;
  int          start_cyc = 0;
  int          cyc = 0;
  int          t;
  logic [10:0] fb;
  logic [7:0]  d;
  bit          go;
  bit          drop_m;
  bit          e_clk, e_data, e_busy, e_full, e_empty;

  // Frame decoder state
  logic        prev_clk = 1'b1;
  int          nfall = 0;
  int          fall_total = 0;
  logic [10:0] rx;

  always @(negedge clk) begin
    cyc++;
    if (s_rst) begin
      fifo_m.delete();
      sent_q.delete();
      ovf_m    = 1'b0;
      in_frame = 1'b0;
      nfall    = 0;
      check_val("reset_state",
                {26'd0, bus.ps2_clk, bus.ps2_data, bus.busy, bus.full, bus.empty, bus.overflow},
                32'b110010);
    end else begin
      go     = !in_frame && (fifo_m.size() > 0) && !s_inh;
      drop_m = s_wr && (fifo_m.size() == DEPTH);
      if (s_wr && !drop_m) fifo_m.push_back(s_data);
      if (drop_m) ovf_m = 1'b1;
      else if (s_clr) ovf_m = 1'b0;
      if (go) begin
        d = fifo_m.pop_front();
        sent_q.push_back(d);
        fb        = {1'b1, ~^d, d, 1'b0};
        start_cyc = cyc;
        in_frame  = 1'b1;
      end
      e_clk  = 1'b1;
      e_data = 1'b1;
      e_busy = 1'b0;
      if (in_frame) begin
        t = cyc - start_cyc;
        if (t < FT) begin
          e_clk  = ((t / HALF) % 2) == 0;
          e_data = fb[t / (2 * HALF)];
        end
        e_busy = (t < BT);
        if (t == BT) in_frame = 1'b0;
      end
      e_full  = (fifo_m.size() == DEPTH);
      e_empty = (fifo_m.size() == 0);
      check_val("lines",
                {26'd0, bus.ps2_clk, bus.ps2_data, bus.busy, bus.full, bus.empty, bus.overflow},
                {26'd0, e_clk, e_data, e_busy, e_full, e_empty, ovf_m});

      if (prev_clk && !bus.ps2_clk) begin
        if (nfall == 0) first_fall.push_back(cyc);
        rx[nfall] = bus.ps2_data;
        nfall++;
        fall_total++;
        if (nfall == 11) begin
          check_val("rx_start", {31'd0, rx[0]}, 32'd0);
          check_val("rx_stop", {31'd0, rx[10]}, 32'd1);
          check_val("rx_parity", {31'd0, ^rx[9:1]}, 32'd1);
          if (sent_q.size() == 0) check_val("rx_unexpected", sent_q.size(), 1);
          else check_val("rx_byte", {24'd0, rx[8:1]}, {24'd0, sent_q.pop_front()});
          nfall = 0;
        end
      end
    end
    prev_clk = bus.ps2_clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en = 1'b0;
  endtask

  int f0;
  int burst = 0;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.inhibit = 1'b0;
    bus.ovf_clr = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (100) step();

    // Single make code
    f0 = fall_total;
    write_byte(8'h1C);
    repeat (PERIOD + 20) step();
    check_val("falls_1c", fall_total - f0, 11);

    // Break sequence back to back
    first_fall.delete();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hF0;
    step();
    bus.wr_data = 8'h1C;
    step();
    bus.wr_en = 1'b0;
    repeat (2 * PERIOD + 30) step();
    check_val("ff_count", first_fall.size(), 2);
    if (first_fall.size() >= 2) check_val("ff_spacing", first_fall[1] - first_fall[0], PERIOD);

    // Fill and overflow under inhibit
    bus.inhibit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h30 + i);
      step();
      if (i == 6) check_val("not_full_7", {31'd0, bus.full}, 32'd0);
      if (i == 7) check_val("full_8", {31'd0, bus.full}, 32'd1);
      if (i == 7) check_val("no_ovf_8", {31'd0, bus.overflow}, 32'd0);
      if (i == 8) check_val("ovf_9", {31'd0, bus.overflow}, 32'd1);
    end
    bus.wr_en = 1'b0;
    f0 = fall_total;
    bus.inhibit = 1'b0;
    repeat (8 * PERIOD + 40) step();
    check_val("falls_8frames", fall_total - f0, 88);
    check_val("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.ovf_clr = 1'b1;
    step();
    bus.ovf_clr = 1'b0;
    check_val("ovf_cleared", {31'd0, bus.overflow}, 32'd0);

    // Inhibit holds off a queued byte; mid-frame inhibit does not abort
    bus.inhibit = 1'b1;
    write_byte(8'h5A);
    f0 = fall_total;
    repeat (200) step();
    check_val("inh_quiet", fall_total - f0, 0);
    bus.inhibit = 1'b0;
    step();
    check_val("inh_start", {31'd0, bus.ps2_data}, 32'd0);
    repeat (7 * HALF) step();
    bus.inhibit = 1'b1;
    repeat (PERIOD) step();
    check_val("inh_mid_frame", fall_total - f0, 11);
    bus.inhibit = 1'b0;

    // Reset in the low phase of bit 5 with bytes queued
    bus.inhibit = 1'b1;
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    bus.inhibit = 1'b0;
    step();
    repeat (11 * HALF) step();
    rst = 1'b1;
    step();
    check_val("rst_mid_lines", {30'd0, bus.ps2_clk, bus.ps2_data}, 32'b11);
    check_val("rst_mid_empty", {31'd0, bus.empty}, 32'd1);
    check_val("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    f0 = fall_total;
    repeat (300) step();
    check_val("rst_mid_quiet", fall_total - f0, 0);

    // Random traffic
    for (int i = 0; i < 6000; i++) begin
      if (burst > 0) begin
        bus.wr_en = 1'b1;
        burst--;
      end else begin
        bus.wr_en = ($urandom_range(0, 59) == 0);
      end
      if ($urandom_range(0, 399) == 0) burst = $urandom_range(3, 12);
      bus.wr_data = 8'($urandom());
      if ($urandom_range(0, 199) == 0) bus.inhibit = ~bus.inhibit;
      bus.ovf_clr = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end
    bus.wr_en   = 1'b0;
    bus.inhibit = 1'b0;
    bus.ovf_clr = 1'b0;
    rst = 1'b0;
    repeat (DEPTH * PERIOD + 20) step();
    check_val("drain_empty", {31'd0, bus.empty}, 32'd1);
    check_val("drain_sent", sent_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
